// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//  Shares one fixed-latency pipelined multiplier between NREQ requesters.
//  One operand pair is granted per cycle (round-robin or fixed priority). The
//  granted pair drives the multiplier inputs. A {vld,id} tag follows the operands
//  down a LATENCY-deep shadow pipeline, so each product returns with its owner's ID.
//
//  Ports
//   clk, rst              clock; asynchronous active-high reset
//   prio_mode             0 = round-robin, 1 = fixed priority (lowest index wins)
//   req_valid/req_a/req_b per-requester operand pairs, requester i at [i*WIDTH +: WIDTH]
//   req_ready             one-hot grant (combinational)
//   mul_a/mul_b           operands to the shared multiplier (combinational)
//   mul_result            product from the shared multiplier
//   rsp_valid/rsp_id      tag at the end of the shadow pipeline
//   rsp_data              product, passed through from mul_result
//   busy                  any tag in flight
module mult_share_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned LATENCY = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    prio_mode,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_result,
   output logic                    rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]      rsp_data,
   output logic                    busy
);

   localparam int unsigned PW = 2 * WIDTH;

   // One stage of the shadow pipeline
   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   tag_t           tag_q [LATENCY];
   tag_t           tag_d [LATENCY];

   logic           grant_vld_c;
   logic [IDW-1:0] grant_id_c;

   // Grant selection; nothing is granted while reset is held
   always_comb begin
      int unsigned idx;
      grant_vld_c = 1'b0;
      grant_id_c  = '0;
      idx         = 0;
      if (!rst) begin
         if (prio_mode) begin
            // Scan downward so the lowest valid index is the last one written
            for (int i = int'(NREQ) - 1; i >= 0; i--) begin
               if (req_valid[i]) begin
                  grant_vld_c = 1'b1;
                  grant_id_c  = IDW'(i);
               end
            end
         end else begin
            // Start one past the last winner and wrap at NREQ-1
            for (int unsigned off = 1; off <= NREQ; off++) begin
               idx = (32'(rr_ptr_q) + off) % NREQ;
               if (!grant_vld_c && req_valid[idx]) begin
                  grant_vld_c = 1'b1;
                  grant_id_c  = IDW'(idx);
               end
            end
         end
      end
   end

   // Grant vector and operand mux; zero operands when idle
   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (grant_vld_c) begin
         req_ready[grant_id_c] = 1'b1;
         mul_a = req_a[32'(grant_id_c) * WIDTH +: WIDTH];
         mul_b = req_b[32'(grant_id_c) * WIDTH +: WIDTH];
      end
   end

   // Pointer follows every transfer, in either mode
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld_c) begin
         rr_ptr_d = grant_id_c;
      end
   end

   // Shadow pipeline: never stalls, matches the multiplier's depth
   always_comb begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
         tag_d[k] = tag_q[k];
      end
      tag_d[0].vld = grant_vld_c;
      tag_d[0].id  = grant_id_c;
      for (int unsigned k = 1; k < LATENCY; k++) begin
         tag_d[k] = tag_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= IDW'(NREQ - 1);
         for (int unsigned k = 0; k < LATENCY; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int unsigned k = 0; k < LATENCY; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   // Response side and in-flight indication
   always_comb begin
      rsp_valid = tag_q[LATENCY-1].vld;
      rsp_id    = tag_q[LATENCY-1].id;
      rsp_data  = PW'(mul_result);
      busy      = 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
         busy = busy | tag_q[k].vld;
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned IDW     = 2;
   localparam int unsigned LATENCY = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  prio_mode = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      mul_a, mul_b;
   logic [2*WIDTH-1:0]    mul_result;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_data;
   logic                  busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   typedef struct {
      int          id;
      logic [15:0] prod;
      int          cyc;
   } exp_t;
   exp_t q[$];
   int   m_ptr = NREQ - 1;

   mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst), .prio_mode(prio_mode), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared pipelined multiplier, same reset as the arbiter
   logic [15:0] mpipe [LATENCY];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(LATENCY); k++) mpipe[k] <= '0;
      end else begin
         mpipe[0] <= 16'(mul_a) * 16'(mul_b);
         for (int k = 1; k < int'(LATENCY); k++) mpipe[k] <= mpipe[k-1];
      end
   end
   assign mul_result = mpipe[LATENCY-1];

   // Reference arbiter: returns the winning index, or -1 when none
   function automatic int exp_grant(input logic [NREQ-1:0] v, input logic mode, input int ptr);
      logic [2*NREQ-1:0] dbl;
      if (mode) begin
         for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
         return -1;
      end
      dbl = {v, v};
      for (int s = ptr + 1; s <= ptr + int'(NREQ); s++) if (dbl[s]) return s % int'(NREQ);
      return -1;
   endfunction

   // Scoreboard monitor: arbitration, operands, responses, busy
   always @(negedge clk) begin
      int          g;
      logic [3:0]  e_rdy;
      logic [7:0]  e_a, e_b;
      logic        e_busy;
      exp_t        e;
      if (rst) begin
         chk_cnt++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            $display("FAIL mon_reset_outputs: rsp_valid=%b busy=%b req_ready=%b required 0/0/0000",
                     rsp_valid, busy, req_ready);
         end else pass_cnt++;
         q.delete();
         m_ptr = NREQ - 1;
      end else begin
         e_busy = (q.size() != 0);
         chk_cnt++;
         if (busy !== e_busy) $display("FAIL mon_busy: got %b required %b (cycle %0d)", busy, e_busy, cyc);
         else pass_cnt++;
         if (rsp_valid === 1'b1) begin
            chk_cnt++;
            if (q.size() == 0) begin
               $display("FAIL mon_rsp_unexpected: rsp_valid=1 id=%0d required no response (cycle %0d)", rsp_id, cyc);
            end else begin
               e = q.pop_front();
               if (int'(rsp_id) !== e.id || rsp_data !== e.prod || cyc != e.cyc + int'(LATENCY))
                  $display("FAIL mon_rsp: id=%0d data=%0d cycle=%0d required id=%0d data=%0d cycle=%0d",
                           rsp_id, rsp_data, cyc, e.id, e.prod, e.cyc + int'(LATENCY));
               else pass_cnt++;
            end
         end else if (q.size() != 0 && q[0].cyc + int'(LATENCY) <= cyc) begin
            chk_cnt++;
            $display("FAIL mon_rsp_missing: rsp_valid=0 required id=%0d data=%0d (cycle %0d)",
                     q[0].id, q[0].prod, cyc);
            void'(q.pop_front());
         end
         g     = exp_grant(req_valid, prio_mode, m_ptr);
         e_rdy = '0;
         e_a   = '0;
         e_b   = '0;
         if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_a = req_a[g*8 +: 8];
            e_b = req_b[g*8 +: 8];
         end
         chk_cnt++;
         if (req_ready !== e_rdy || mul_a !== e_a || mul_b !== e_b)
            $display("FAIL mon_grant: ready=%b a=%0d b=%0d required ready=%b a=%0d b=%0d (cycle %0d)",
                     req_ready, mul_a, mul_b, e_rdy, e_a, e_b, cyc);
         else pass_cnt++;
         if (g >= 0) begin
            e.id   = g;
            e.prod = 16'(e_a) * 16'(e_b);
            e.cyc  = cyc;
            q.push_back(e);
            m_ptr = g;
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]    = v;
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; req_valid = '0; prio_mode = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (q.size() == 0 && busy === 1'b0) done = 1;
      end
      chk_cnt++;
      if (!done) $display("FAIL wait_idle: pending=%0d busy=%b required 0 and 0", q.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0)
         $display("FAIL reset_state: rsp_valid=%b rsp_id=%0d busy=%b ready=%b required 0/0/0/0000",
                  rsp_valid, rsp_id, busy, req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || mul_a !== 8'd0 || mul_b !== 8'd0)
         $display("FAIL idle_after_reset: rsp_valid=%b busy=%b ready=%b a=%0d b=%0d required all 0",
                  rsp_valid, busy, req_ready, mul_a, mul_b);
      else pass_cnt++;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      set_req(0, 1'b1, 8'd3, 8'd5);
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0001) $display("FAIL single_grant: ready=%b required 0001", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL single_early: rsp_valid=%b required 0 at cycle 3", rsp_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd15)
         $display("FAIL single_rsp: valid=%b id=%0d data=%0d required 1/0/15", rsp_valid, rsp_id, rsp_data);
      else pass_cnt++;
      wait_idle();
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      do_reset();
      @(posedge clk); #1;
      set_req(0, 1'b1, 8'd255, 8'd255);
      set_req(1, 1'b1, 8'd17, 8'd3);
      set_req(2, 1'b1, 8'd128, 8'd2);
      set_req(3, 1'b1, 8'd200, 8'd201);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         e = '0;
         e[k % 4] = 1'b1;
         chk_cnt++;
         if (req_ready !== e) $display("FAIL rr_grant_%0d: ready=%b required %b", k, req_ready, e);
         else pass_cnt++;
         if (k >= 4) begin
            chk_cnt++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != k - 4)
               $display("FAIL rr_rsp_%0d: valid=%b id=%0d required 1/%0d", k, rsp_valid, rsp_id, k - 4);
            else pass_cnt++;
         end
         if (k == 4) begin
            chk_cnt++;
            if (rsp_data !== 16'd65025) $display("FAIL rr_max_product: data=%0d required 65025", rsp_data);
            else pass_cnt++;
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_fixed_prio();
      @(posedge clk); #1;
      req_valid = 4'b1111;
      prio_mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_cnt++;
         if (req_ready !== 4'b0001) $display("FAIL fp_grant_%0d: ready=%b required 0001", k, req_ready);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      prio_mode = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0010) $display("FAIL fp_switch_rr: ready=%b required 0010", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0100) $display("FAIL fp_switch_rr2: ready=%b required 0100", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_sparse();
      do_reset();
      @(posedge clk); #1;
      set_req(2, 1'b1, 8'd7, 8'd9);
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0100) $display("FAIL sparse_grant2: ready=%b required 0100", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      set_req(1, 1'b1, 8'd11, 8'd13);
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0010) $display("FAIL sparse_grant1: ready=%b required 0010", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'd63)
         $display("FAIL sparse_rsp2: valid=%b id=%0d data=%0d required 1/2/63", rsp_valid, rsp_id, rsp_data);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL sparse_gap: rsp_valid=%b required 0", rsp_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd143 || busy !== 1'b1)
         $display("FAIL sparse_rsp1: valid=%b id=%0d data=%0d busy=%b required 1/1/143/1",
                  rsp_valid, rsp_id, rsp_data, busy);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0)
         $display("FAIL sparse_idle: busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
      else pass_cnt++;
      // Pointer now sits at 1, so the next round-robin winner is 2
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0100) $display("FAIL sparse_ptr: ready=%b required 0100", req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle();
   endtask

   task automatic test_reset_midflight();
      @(posedge clk); #1;
      req_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000)
         $display("FAIL midreset_outputs: rsp_valid=%b busy=%b ready=%b required 0/0/0000",
                  rsp_valid, busy, req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_cnt++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_stale_%0d: rsp_valid=%b busy=%b required 0/0", k, rsp_valid, busy);
         else pass_cnt++;
      end
      @(posedge clk); #1;
      set_req(3, 1'b1, 8'd12, 8'd12);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'd144)
         $display("FAIL midreset_new: valid=%b id=%0d data=%0d required 1/3/144", rsp_valid, rsp_id, rsp_data);
      else pass_cnt++;
      wait_idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 10000; n++) begin
         @(posedge clk); #1;
         req_valid = 4'($urandom);
         prio_mode = ($urandom_range(0, 7) == 0);
         req_a     = $urandom;
         req_b     = $urandom;
      end
      @(posedge clk); #1;
      req_valid = '0;
      prio_mode = 1'b0;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fixed_prio();
      test_sparse();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
